// File: rtl/xc_aessub_seq.sv
// Multi-cycle AES SubBytes for a 32-bit word: LANES fwd/inv S-box cells are
// time-multiplexed over the four bytes, with optional rotate-left-by-8 on the result.

module xc_aessub_sbox (
    input  logic [7:0] din,
    input  logic       inv,
    output logic [7:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] pre;
    logic [7:0] ginv;

    always_comb begin
        pre  = inv ? inv_affine(din) : din;
        ginv = gf_inv(pre);
        dout = inv ? ginv : fwd_affine(ginv);
    end

endmodule

module xc_aessub_seq #(
    parameter int LANES = 1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_rs1,
    input  logic        req_inv,
    input  logic        req_rot,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        busy
);

    localparam int STEPS = 4 / LANES;
    localparam int CTR_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("xc_aessub_seq: LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [CTR_W-1:0]   ctr;
    logic [31:0]        op_rs1;
    logic               op_inv;
    logic               op_rot;
    logic [31:0]        res;

    logic [1:0]         cell_idx [LANES];
    logic [7:0]         cell_out [LANES];

    // Cell k owns byte ctr*LANES+k during each BUSY cycle.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            cell_idx[k] = 2'(int'(ctr) * LANES + k);
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_cell
        xc_aessub_sbox u_sbox (
            .din  (op_rs1[{cell_idx[k], 3'b000} +: 8]),
            .inv  (op_inv),
            .dout (cell_out[k])
        );
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state  <= IDLE;
            ctr    <= '0;
            op_rs1 <= '0;
            op_inv <= 1'b0;
            op_rot <= 1'b0;
            res    <= '0;
        end else if (flush) begin
            state <= IDLE;
            ctr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_rs1 <= req_rs1;
                        op_inv <= req_inv;
                        op_rot <= req_rot;
                        ctr    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    for (int k = 0; k < LANES; k++) begin
                        res[{cell_idx[k], 3'b000} +: 8] <= cell_out[k];
                    end
                    if (ctr == CTR_W'(STEPS - 1)) begin
                        ctr   <= '0;
                        state <= DONE;
                    end else begin
                        ctr <= ctr + CTR_W'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result is gated by rsp_valid so partially written words never leak out.
    assign req_ready  = (state == IDLE) && !flush;
    assign rsp_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign rsp_result = !rsp_valid ? 32'h0 : (op_rot ? {res[23:0], res[31:24]} : res);

endmodule

// File: tb/tb_xc_aessub_seq.sv
// Bench for xc_aessub_seq: one instance per legal LANES value, a scoreboard
// queue per instance, directed vectors plus table-model random round trips.

module tb_xc_aessub_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  flush;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_inv;
    logic [2:0]  req_rot;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_ready;
    logic [2:0]  busy;
    logic [31:0] req_rs1    [3];
    logic [31:0] rsp_result [3];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [3][$];
    logic [7:0]  sbox_tab  [256];
    logic [7:0]  isbox_tab [256];
    int          steps_tab [3] = '{4, 2, 1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        xc_aessub_seq #(.LANES(1 << g)) u_dut (
            .g_clk      (clk),
            .g_resetn   (rst_n),
            .flush      (flush[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_rs1    (req_rs1[g]),
            .req_inv    (req_inv[g]),
            .req_rot    (req_rot[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_result (rsp_result[g]),
            .busy       (busy[g])
        );
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] w, input logic inv, input logic rot);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = inv ? isbox_tab[w[8*i +: 8]] : sbox_tab[w[8*i +: 8]];
        end
        return rot ? {r[23:0], r[31:24]} : r;
    endfunction

    // Scoreboard monitor: pops on every response handshake.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 3; d++) begin
                if (rsp_valid[d] && rsp_ready[d]) begin
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp dut%0d: got %h expected none", d, rsp_result[d]);
                    end else begin
                        e = exp_q[d].pop_front();
                        check32($sformatf("rsp dut%0d", d), rsp_result[d], e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int d, input logic [31:0] w, input logic inv, input logic rot);
        int n = 0;
        while (!req_ready[d] && n < 50) begin
            step();
            n++;
        end
        if (!req_ready[d]) check32($sformatf("accept_timeout dut%0d", d), {31'b0, req_ready[d]}, 32'd1);
        req_rs1[d]   = w;
        req_inv[d]   = inv;
        req_rot[d]   = rot;
        req_valid[d] = 1'b1;
        step();
        req_valid[d] = 1'b0;
        req_rs1[d]   = $urandom;
        req_inv[d]   = 1'($urandom_range(0, 1));
        req_rot[d]   = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_rsp(input int d);
        int n = 0;
        while (!rsp_valid[d] && n < 30) begin
            check32($sformatf("ready_low_busy dut%0d", d), {31'b0, req_ready[d]}, 32'd0);
            check32($sformatf("result_hidden dut%0d", d), rsp_result[d], 32'h0);
            step();
            n++;
        end
        check32($sformatf("latency dut%0d", d), n, steps_tab[d]);
    endtask

    task automatic run_op(input int d, input logic [31:0] w, input logic inv, input logic rot,
                          input logic [31:0] exp);
        int n = 0;
        exp_q[d].push_back(exp);
        accept(d, w, inv, rot);
        wait_rsp(d);
        while (rsp_valid[d] && n < 30) begin
            step();
            n++;
        end
        check32($sformatf("rsp_drop dut%0d", d), {31'b0, rsp_valid[d]}, 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin : main
        logic [0:2047] sbox_bits;
        logic [31:0]   w;
        logic [31:0]   f;
        logic          inv;
        logic          rot;
        int            seen;

        sbox_bits = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_bits[8*i +: 8];
        for (int i = 0; i < 256; i++) isbox_tab[sbox_tab[i]] = 8'(i);

        // Clock/reset
        rst_n     = 1'b1;
        flush     = '0;
        req_valid = '0;
        req_inv   = '0;
        req_rot   = '0;
        rsp_ready = '1;
        for (int d = 0; d < 3; d++) req_rs1[d] = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        for (int d = 0; d < 3; d++) begin
            check32($sformatf("rst_req_ready dut%0d", d), {31'b0, req_ready[d]}, 32'd1);
            check32($sformatf("rst_rsp_valid dut%0d", d), {31'b0, rsp_valid[d]}, 32'd0);
            check32($sformatf("rst_rsp_result dut%0d", d), rsp_result[d], 32'h0);
            check32($sformatf("rst_busy dut%0d", d), {31'b0, busy[d]}, 32'd0);
        end

        // Directed vectors
        run_op(0, 32'h00010253, 1'b0, 1'b0, 32'h637C77ED);
        run_op(2, 32'h00010253, 1'b0, 1'b1, 32'h7C77ED63);
        run_op(2, 32'h637C77ED, 1'b1, 1'b0, 32'h00010253);
        run_op(1, 32'h00010253, 1'b0, 1'b1, 32'h7C77ED63);

        // Response back-pressure on the LANES=2 unit
        rsp_ready[1] = 1'b0;
        exp_q[1].push_back(32'hFFFFFFFF);
        accept(1, 32'h16161616, 1'b1, 1'b0);
        wait_rsp(1);
        for (int i = 0; i < 4; i++) begin
            check32("stall_valid", {31'b0, rsp_valid[1]}, 32'd1);
            check32("stall_result", rsp_result[1], 32'hFFFFFFFF);
            step();
        end
        rsp_ready[1] = 1'b1;
        step();
        check32("post_stall_ready", {31'b0, req_ready[1]}, 32'd1);
        check32("post_stall_valid", {31'b0, rsp_valid[1]}, 32'd0);
        check32("post_stall_busy", {31'b0, busy[1]}, 32'd0);

        // Flush in the second BUSY cycle of the LANES=1 unit
        accept(0, 32'h00010253, 1'b0, 1'b0);
        step();
        check32("flush_busy_before", {31'b0, busy[0]}, 32'd1);
        flush[0] = 1'b1;
        step();
        flush[0] = 1'b0;
        check32("flush_busy_after", {31'b0, busy[0]}, 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid[0]) seen++;
            step();
        end
        check32("flush_no_rsp", seen, 0);
        run_op(0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h16161616);

        // Flush and request together in IDLE
        for (int d = 0; d < 3; d++) begin
            flush[d]     = 1'b1;
            req_valid[d] = 1'b1;
            req_rs1[d]   = 32'hA5A5A5A5;
            #1;
            check32($sformatf("flush_req_ready dut%0d", d), {31'b0, req_ready[d]}, 32'd0);
            step();
            flush[d]     = 1'b0;
            req_valid[d] = 1'b0;
            check32($sformatf("flush_req_busy dut%0d", d), {31'b0, busy[d]}, 32'd0);
            step();
            check32($sformatf("flush_req_valid dut%0d", d), {31'b0, rsp_valid[d]}, 32'd0);
        end

        // Asynchronous reset during BUSY
        accept(0, 32'h12345678, 1'b0, 1'b0);
        check32("pre_reset_busy", {31'b0, busy[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check32("async_rst_busy", {31'b0, busy[0]}, 32'd0);
        check32("async_rst_valid", {31'b0, rsp_valid[0]}, 32'd0);
        check32("async_rst_result", rsp_result[0], 32'h0);
        #1 rst_n = 1'b1;
        step();
        check32("post_rst_ready", {31'b0, req_ready[0]}, 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid[0]) seen++;
            step();
        end
        check32("post_rst_no_rsp", seen, 0);

        // Random words against the table model, plus fwd/inv round trips
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                w   = $urandom;
                inv = 1'($urandom_range(0, 1));
                rot = 1'($urandom_range(0, 1));
                run_op(d, w, inv, rot, model(w, inv, rot));
            end
            for (int i = 0; i < 3; i++) begin
                w = $urandom;
                f = model(w, 1'b0, 1'b0);
                run_op(d, w, 1'b0, 1'b0, f);
                run_op(d, f, 1'b1, 1'b0, w);
            end
        end

        step();
        for (int d = 0; d < 3; d++) begin
            check32($sformatf("queue_empty dut%0d", d), exp_q[d].size(), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xc_aessub_seq.md
Name: xc_aessub_seq

Overview:
- Parametrised multi-cycle AES SubBytes unit for a full 32-bit word, with forward/inverse selection and optional byte rotation of the result.
- Time-multiplexes LANES instances of the single-byte fwd/inv S-box cell `xc_aessub_sbox` over the 4 bytes, trading latency for area.
- Sits behind the xcrypto execute stage with a valid/ready request/response handshake and a pipeline flush input.

Parameters:
- LANES, 1, number of S-box cells instantiated. Legal values are 1, 2, 4; any other value is an elaboration error.
- STEPS, 4/LANES, derived localparam, not overridable: cycles spent in BUSY per operation.

Ports:
- g_clk  in  1  clock; all state updates on rising edge.
- g_resetn  in  1  asynchronous active-low reset.
- flush  in  1  abort any operation in progress.
- req_valid  in  1  request valid.
- req_ready  out  1  unit can accept a request.
- req_rs1  in  32  input word; byte i = req_rs1[8i+7:8i].
- req_inv  in  1  1 = inverse S-box, 0 = forward.
- req_rot  in  1  1 = rotate result left by 8 bits.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  32  substituted (optionally rotated) word.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (g_resetn low, asynchronous):
  - state = IDLE, ctr = 0, result register = 0.
  - Outputs: req_ready = 1 after reset deassert, rsp_valid = 0, rsp_result = 0, busy = 0.
- States and transitions:
  - IDLE: req_ready = !flush. On req_valid && req_ready, latch rs1, inv, rot into operand registers; ctr = 0; go to BUSY.
  - BUSY: each cycle, cell k (0..LANES-1) processes byte ctr*LANES+k of the latched operand with the latched inv. Its output is written to the same byte of the result register. ctr increments; after the cycle with ctr = STEPS-1, go to DONE.
  - DONE: rsp_valid = 1. On rsp_ready, go to IDLE.
- Handshake:
  - req_ready is low in BUSY and DONE. No back-to-back acceptance; at most one operation outstanding.
  - Latency: a request accepted in cycle T gives rsp_valid high in cycle T+STEPS+1 (LANES=4 → T+2, LANES=1 → T+5).
  - rsp_valid and rsp_result stay stable until rsp_ready is sampled high.
  - rsp_result is combinational from the result register: rot ? {res[23:0],res[31:24]} : res. It is 0 whenever rsp_valid = 0, so bytes are never exposed partially.
- Flush:
  - In any state, the next state is IDLE and ctr = 0. No response is produced for the aborted operation, and rsp_valid drops the next cycle.
  - flush and req_valid in the same IDLE cycle: flush wins, the request is not accepted (req_ready = 0).
  - flush and rsp_ready in the same DONE cycle: the result counts as consumed; next state is IDLE either way.
- ctr is log2(STEPS) bits wide (1 bit minimum) and wraps only through the BUSY→DONE transition; it never exceeds STEPS-1.
- Changes on req_* inputs while not in IDLE are ignored, because operand registers load only on acceptance.
- Asynchronous reset mid-operation behaves like flush, but takes effect immediately and clears the result register.

Test Plan:
- LANES=1, fwd, req_rs1=0x00010253, rot=0 → rsp_result=0x637C77ED; rsp_valid first high 5 cycles after acceptance; req_ready low throughout.
- LANES=4, fwd, rot=1, req_rs1=0x00010253 → rsp_result=0x7C77ED63, 2 cycles after acceptance; then inv, rot=0, req_rs1=0x637C77ED → 0x00010253.
- LANES=2, inv, req_rs1=0x16161616 → 0xFFFFFFFF after 3 cycles; rsp_ready held low 4 cycles → result and rsp_valid stable; rsp_ready high → IDLE next cycle, req_ready=1.
- LANES=1, flush asserted in the 2nd BUSY cycle → no rsp_valid ever for that operation. A new request 0xFFFFFFFF fwd is accepted afterwards → 0x16161616, with no stale bytes from the aborted operation.
- Any LANES, flush and req_valid in the same IDLE cycle → req_ready=0, no acceptance, busy stays 0; g_resetn pulsed low during BUSY → all outputs at reset values immediately.
- Random 32-bit words with random inv/rot, all three LANES values → compare against a byte-wise AES S-box model; fwd then inv round-trip returns the original word.
